// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master drives the decode/EX hazard inputs; the slave returns the enables, flushes and status.
interface pipeline_hazard_ctrl_if;
    logic        idValid;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUsesRt;
    logic [4:0]  exRW;
    logic        exMemRead;
    logic        exMulDivStart;
    logic        branchTaken;
    logic        stallClear;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        idExWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        mdBusy;
    logic        mdDone;
    logic [15:0] stallCount;

    modport master (
        output idValid, idRs, idRt, idUsesRt, exRW, exMemRead, exMulDivStart,
               branchTaken, stallClear,
        input  pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, mdBusy, mdDone,
               stallCount
    );

    modport slave (
        input  idValid, idRs, idRt, idUsesRt, exRW, exMemRead, exMulDivStart,
               branchTaken, stallClear,
        output pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, mdBusy, mdDone,
               stallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush and a multi-cycle mul/div freeze,
// plus a saturating counter of PC-stall cycles.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_ctrl_if.slave       hz
);

    if (MD_LATENCY < 2 || MD_LATENCY > 16) begin : g_bad_latency
        $error("pipeline_hazard_ctrl: MD_LATENCY must be in 2..16");
    end

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  mdCnt;
    logic [3:0]  mdCntNext;
    logic [15:0] stallCount;

    logic        loadUse;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        idExWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        mdBusy;
    logic        mdDone;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Register zero is hard-wired, so a load targeting it can never create a dependency.
    assign loadUse = hz.exMemRead && (hz.exRW != 5'd0) && hz.idValid &&
                     ((hz.exRW == hz.idRs) || (hz.idUsesRt && (hz.exRW == hz.idRt)));

    always_comb begin
        stateNext = state;
        mdCntNext = mdCnt;
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        idExWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        mdBusy    = 1'b0;
        mdDone    = 1'b0;

        case (state)
            RUN: begin
                if (hz.branchTaken) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (hz.exMulDivStart) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    idExWrite = 1'b0;
                    mdCntNext = MD_LOAD;
                    stateNext = MD_BUSY;
                end else if (loadUse) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    idExFlush = 1'b1;
                end
            end
            MD_BUSY: begin
                mdBusy = 1'b1;
                if (mdCnt > 4'd1) begin
                    pcWrite   = 1'b0;
                    ifIdWrite = 1'b0;
                    idExWrite = 1'b0;
                    mdCntNext = mdCnt - 4'd1;
                end else begin
                    mdDone    = 1'b1;
                    mdCntNext = 4'd0;
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
                mdCntNext = 4'd0;
            end
        endcase

        // Reset is asynchronous, so the decode must show bubble values without waiting for an edge.
        if (!rst_n) begin
            stateNext = RUN;
            mdCntNext = 4'd0;
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExWrite = 1'b0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            mdBusy    = 1'b0;
            mdDone    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mdCnt <= 4'd0;
        end else begin
            state <= stateNext;
            mdCnt <= mdCntNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= 16'd0;
        end else if (hz.stallClear) begin
            stallCount <= 16'd0;
        end else if (!pcWrite) begin
            stallCount <= sat_inc(stallCount);
        end
    end

    assign hz.pcWrite    = pcWrite;
    assign hz.ifIdWrite  = ifIdWrite;
    assign hz.idExWrite  = idExWrite;
    assign hz.ifIdFlush  = ifIdFlush;
    assign hz.idExFlush  = idExFlush;
    assign hz.mdBusy     = mdBusy;
    assign hz.mdDone     = mdDone;
    assign hz.stallCount = stallCount;

endmodule
